cpu_sramlike_bridge: RTL and testbench
======================================

Name: cpu_sramlike_bridge

Overview:
- Parametrised successor to the CPU's fixed single-cycle SRAM port.
- Converts one CPU memory port (en/wen/addr/wdata/rdata) into a SRAM-like handshake bus (req/addr_ok/data_ok).
- Stalls the pipeline while a transaction is in flight, and holds the read data while the pipeline is stalled for other reasons.
- One instance is placed on the instruction port and one on the data port, between the datapath and the bus arbiter.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; legal values are 32 or 64
SIZE_W, 2, width of the bus size field

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
cpu_en  input  1  CPU access request; level, held until cpu_stall falls
cpu_wen  input  DATA_W/8  byte write mask; all zero means read
cpu_addr  input  ADDR_W  access address
cpu_wdata  input  DATA_W  write data
cpu_rdata  output  DATA_W  read data returned to the CPU
cpu_hold  input  1  pipeline stalled by another source; completed result must be held
cpu_flush  input  1  exception/flush; discard the current access
cpu_stall  output  1  stall request to the hazard unit
req  output  1  bus request
wr  output  1  1 = write
size  output  SIZE_W  log2 of the number of bytes
addr  output  ADDR_W  bus address
wdata  output  DATA_W  bus write data
addr_ok  input  1  request accepted
data_ok  input  1  data returned / write done
rdata  input  DATA_W  bus read data

Behaviour:
- Reset: asynchronous and active-low. State = IDLE; req, wr, size, addr, wdata, cpu_rdata and the drop flag all 0; cpu_stall = 0 while resetn is low.
- States: IDLE, REQ, WAIT, DONE. All outputs except cpu_stall are registered.
- IDLE:
  - cpu_en=1 and cpu_flush=0: latch addr, wdata, wr=|cpu_wen and size; next state REQ.
  - Otherwise stay in IDLE.
- REQ:
  - req=1; addr, wr, size and wdata are stable.
  - addr_ok=1: req falls; next state WAIT.
  - req is never withdrawn before addr_ok, including on flush.
- WAIT:
  - data_ok=1: capture cpu_rdata<=rdata (reads only; writes leave cpu_rdata unchanged).
  - Next state is DONE, or IDLE if the drop flag is set.
- DONE:
  - cpu_rdata is held.
  - cpu_hold=0 or cpu_flush=1: next state IDLE.
  - Otherwise stay in DONE for any number of cycles.
- The bus guarantees data_ok arrives at least one cycle after addr_ok. data_ok in IDLE, REQ or DONE is ignored.
- cpu_stall (combinational) = (state==IDLE & cpu_en & ~cpu_flush) | state==REQ | state==WAIT.
- Drop flag:
  - Set by cpu_flush in REQ or WAIT; cleared on entry to IDLE.
  - While set, the transaction completes on the bus, cpu_rdata is not updated and the state returns to IDLE.
  - cpu_stall stays high until that return, so no new request overlaps.
- Size generation:
  - Read: size = log2(DATA_W/8).
  - Write: size = log2(popcount(cpu_wen)) for aligned contiguous masks: single byte gives 0, aligned halfword gives 1, aligned word gives 2, all-ones at 64 bits gives 3.
  - Any other mask gives the full-width size.
- Minimum latency is 3 cycles from cpu_en to stall low: IDLE, then REQ with same-cycle addr_ok, then WAIT with data_ok, then DONE.
- Back-to-back accesses: DONE to IDLE costs one cycle before the next REQ.
- Reset mid-transaction returns to IDLE immediately. The bus side is expected to be reset together with this block.

Test Plan:
1. Read, zero wait. cpu_en=1, wen=0, addr=0xBFC00000; addr_ok in the REQ cycle, data_ok next cycle with rdata=0x3C1DBFC1 -> req high 1 cycle, wr=0, size=2, stall high 3 cycles, cpu_rdata=0x3C1DBFC1 in DONE.
2. Byte and halfword writes. wen=0100, addr=0x80000002, wdata=0x00AA0000 -> wr=1, size=0, addr passed through. wen=1100 -> size=1. wen=0101 -> size=2. cpu_rdata unchanged in all cases.
3. Waits. addr_ok delayed 4 cycles, then data_ok delayed 3 cycles -> req and addr held stable for 5 cycles, stall high throughout, exactly one transaction issued.
4. Hold. Complete a read with rdata=0x12345678, keep cpu_hold=1 for 5 cycles while bus rdata changes -> cpu_rdata stays 0x12345678, stall low, no new req; drop cpu_hold -> IDLE next cycle.
5. Flush. Pulse cpu_flush in REQ -> req held until addr_ok, data_ok consumed, cpu_rdata unchanged, return to IDLE without DONE. Flush in IDLE with cpu_en=1 -> no request issued.
6. Reset and width. Assert resetn=0 in WAIT -> all outputs 0 asynchronously. With DATA_W=64 and wen=0xFF -> size=3; a read also gives size=3.

Source files
------------

// File: rtl/cpu_sramlike_bridge.sv
// CPU memory port to SRAM-like req/addr_ok/data_ok bus bridge.
// Stalls the pipeline per transaction and holds read data across stalls.
module cpu_sramlike_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                cpu_hold,
  input  logic                cpu_flush,
  output logic                cpu_stall,
  output logic                req,
  output logic                wr,
  output logic [SIZE_W-1:0]   size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;
  localparam int LG = $clog2(NB);
  localparam logic [SIZE_W-1:0] SZ_FULL = SIZE_W'(LG);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic              r_drop;
  logic              w_drop;
  logic              w_wr;
  logic [SIZE_W-1:0] w_size;
  logic [NB-1:0]     w_pat;

  assign w_wr   = |cpu_wen;
  assign w_drop = r_drop | cpu_flush;

  // Only naturally aligned power-of-two byte runs get a narrow size.
  always_comb begin
    w_size = SZ_FULL;
    w_pat  = '0;
    for (int s = 0; s <= LG; s++) begin
      for (int k = 0; k < NB; k += (1 << s)) begin
        w_pat = '1;
        w_pat = w_pat >> (NB - (1 << s));
        w_pat = w_pat << k;
        if (cpu_wen == w_pat) w_size = SIZE_W'(s);
      end
    end
  end

  assign cpu_stall = resetn & (
    (r_state == S_IDLE & cpu_en & ~cpu_flush) |
    (r_state == S_REQ) |
    (r_state == S_WAIT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_drop    <= 1'b0;
      req       <= 1'b0;
      wr        <= 1'b0;
      size      <= '0;
      addr      <= '0;
      wdata     <= '0;
      cpu_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_drop <= 1'b0;
          if (cpu_en && !cpu_flush) begin
            req     <= 1'b1;
            wr      <= w_wr;
            size    <= w_wr ? w_size : SZ_FULL;
            addr    <= cpu_addr;
            wdata   <= cpu_wdata;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (cpu_flush) r_drop <= 1'b1;
          if (addr_ok) begin
            req     <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A flushed access still drains the bus, then returns silently.
          r_drop <= data_ok ? 1'b0 : w_drop;
          if (data_ok) begin
            if (!wr && !w_drop) cpu_rdata <= rdata;
            r_state <= w_drop ? S_IDLE : S_DONE;
          end
        end
        S_DONE: begin
          if (!cpu_hold || cpu_flush) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sramlike_bridge.sv
// Bench for cpu_sramlike_bridge: vector table, scoreboard, corner cases.
// Covers 32-bit instance fully and a 64-bit instance for size encoding.
module tb_cpu_sramlike_bridge;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          adly;
    int          ddly;
    logic        exp_wr;
    logic [1:0]  exp_size;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_en, cpu_hold, cpu_flush;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, req, wr, addr_ok, data_ok;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;

  logic        c6_en, c6_stall, c6_req, c6_wr, c6_aok, c6_dok;
  logic [7:0]  c6_wen;
  logic [1:0]  c6_size;
  logic [31:0] c6_addr, c6_baddr;
  logic [63:0] c6_wdata, c6_rdata, c6_bwdata, c6_brdata;

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int req_cnt = 0;
  logic prev_req = 1'b0;
  logic [31:0] exp_rdata = '0;
  req_t sbq[$];
  vec_t vt[10];

  always #5 clk = ~clk;

  cpu_sramlike_bridge #(.ADDR_W(32), .DATA_W(32), .SIZE_W(2)) u32 (
    .clk(clk), .resetn(resetn),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_hold(cpu_hold), .cpu_flush(cpu_flush), .cpu_stall(cpu_stall),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  cpu_sramlike_bridge #(.ADDR_W(32), .DATA_W(64), .SIZE_W(2)) u64 (
    .clk(clk), .resetn(resetn),
    .cpu_en(c6_en), .cpu_wen(c6_wen), .cpu_addr(c6_addr),
    .cpu_wdata(c6_wdata), .cpu_rdata(c6_rdata),
    .cpu_hold(1'b0), .cpu_flush(1'b0), .cpu_stall(c6_stall),
    .req(c6_req), .wr(c6_wr), .size(c6_size), .addr(c6_baddr),
    .wdata(c6_bwdata),
    .addr_ok(c6_aok), .data_ok(c6_dok), .rdata(c6_brdata)
  );

  always @(negedge clk) begin
    if (req && !prev_req) req_cnt++;
    prev_req = req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_chk(input string nm);
    req_t g;
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 1, 0);
    end else begin
      g = sbq.pop_front();
      chk(nm, {req, wr, size, addr, wdata},
          {1'b1, g.wr, g.size, g.addr, g.wdata});
    end
  endtask

  task automatic push_req(input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d);
    req_t e;
    e.wr = w; e.size = s; e.addr = a; e.wdata = d;
    sbq.push_back(e);
    pushed++;
  endtask

  // Starts in IDLE at a negedge, returns at the DONE-state negedge.
  task automatic txn(input vec_t v);
    int sc, rc;
    sc = 0;
    rc = 0;
    push_req(v.exp_wr, v.exp_size, v.addr, v.wdata);
    cpu_en = 1'b1;
    cpu_wen = v.wen;
    cpu_addr = v.addr;
    cpu_wdata = v.wdata;
    #1 if (cpu_stall) sc++;
    tick();
    pop_chk("req_fields");
    for (int i = 0; i <= v.adly; i++) begin
      if (req && addr == v.addr && wr == v.exp_wr) rc++;
      if (cpu_stall) sc++;
      addr_ok = (i == v.adly);
      tick();
    end
    addr_ok = 1'b0;
    for (int i = 0; i <= v.ddly; i++) begin
      if (req) rc++;
      if (cpu_stall) sc++;
      data_ok = (i == v.ddly);
      rdata = (i == v.ddly) ? v.rd : ~v.rd;
      tick();
    end
    data_ok = 1'b0;
    if (!v.exp_wr) exp_rdata = v.rd;
    if (cpu_stall) sc++;
    chk("stall_cycles", sc, v.adly + v.ddly + 3);
    chk("req_cycles", rc, v.adly + 1);
    chk("cpu_rdata", cpu_rdata, exp_rdata);
    cpu_en = 1'b0;
    cpu_wen = '0;
  endtask

  task automatic t64(input logic [7:0] m, input logic [1:0] es);
    c6_en = 1'b1;
    c6_wen = m;
    c6_addr = 32'h0000_0040;
    tick();
    chk("size64", {c6_req, c6_wr, c6_size}, {1'b1, |m, es});
    c6_aok = 1'b1;
    tick();
    c6_aok = 1'b0;
    c6_dok = 1'b1;
    tick();
    c6_dok = 1'b0;
    c6_en = 1'b0;
    chk("stall64_done", c6_stall, 0);
    tick();
  endtask

  initial begin
    vt[0] = '{4'b0000, 32'hBFC00000, 32'h0, 32'h3C1DBFC1, 0, 0, 1'b0, 2'd2};
    vt[1] = '{4'b0100, 32'h80000002, 32'h00AA0000, 32'h55555555, 0, 0, 1'b1, 2'd0};
    vt[2] = '{4'b1100, 32'h80000002, 32'hAABB0000, 32'h66666666, 0, 0, 1'b1, 2'd1};
    vt[3] = '{4'b0101, 32'h80000000, 32'h00CC00DD, 32'h77777777, 0, 0, 1'b1, 2'd2};
    vt[4] = '{4'b0001, 32'h80000010, 32'h000000EE, 32'h88888888, 1, 0, 1'b1, 2'd0};
    vt[5] = '{4'b0011, 32'h80000020, 32'h0000BEEF, 32'h99999999, 0, 1, 1'b1, 2'd1};
    vt[6] = '{4'b0110, 32'h80000030, 32'h00ABCD00, 32'hAAAAAAAA, 1, 1, 1'b1, 2'd2};
    vt[7] = '{4'b1111, 32'h80000040, 32'h01020304, 32'hBBBBBBBB, 0, 0, 1'b1, 2'd2};
    vt[8] = '{4'b1000, 32'h80000053, 32'h7F000000, 32'hCCCCCCCC, 2, 0, 1'b1, 2'd0};
    vt[9] = '{4'b0000, 32'h00001000, 32'h0, 32'hCAFEF00D, 4, 3, 1'b0, 2'd2};

    resetn = 1'b0;
    cpu_en = 0; cpu_hold = 0; cpu_flush = 0; cpu_wen = 0;
    cpu_addr = 0; cpu_wdata = 0; addr_ok = 0; data_ok = 0; rdata = 0;
    c6_en = 0; c6_wen = 0; c6_addr = 0; c6_wdata = 0;
    c6_aok = 0; c6_dok = 0; c6_brdata = 0;
    #1;
    chk("reset_outputs",
        {req, wr, size, addr, wdata, cpu_rdata, cpu_stall}, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      txn(vt[i]);
      tick();
    end

    // Hold: result must survive pipeline stall while bus rdata moves.
    cpu_hold = 1'b1;
    txn('{4'b0000, 32'h00002000, 32'h0, 32'h12345678, 0, 0, 1'b0, 2'd2});
    for (int i = 0; i < 5; i++) begin
      rdata = $urandom;
      tick();
      chk("hold_data", {cpu_rdata, cpu_stall, req}, {32'h12345678, 2'b00});
    end
    cpu_hold = 1'b0;
    tick();
    cpu_en = 1'b1;
    #1 chk("hold_release_idle", cpu_stall, 1);
    cpu_en = 1'b0;
    tick();

    // Flush during REQ: bus completes, CPU sees nothing, no DONE.
    push_req(1'b0, 2'd2, 32'h00003000, 32'h0);
    cpu_en = 1'b1;
    cpu_addr = 32'h00003000;
    cpu_wdata = 32'h0;
    tick();
    pop_chk("flush_req_fields");
    cpu_flush = 1'b1;
    tick();
    cpu_flush = 1'b0;
    cpu_en = 1'b0;
    chk("flush_req_held", {req, cpu_stall}, 2'b11);
    tick();
    chk("flush_req_held2", {req, cpu_stall}, 2'b11);
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    chk("flush_wait", {req, cpu_stall}, 2'b01);
    data_ok = 1'b1;
    rdata = 32'hDEADBEEF;
    tick();
    data_ok = 1'b0;
    chk("flush_rdata", cpu_rdata, exp_rdata);
    cpu_en = 1'b1;
    #1 chk("flush_back_idle", cpu_stall, 1);

    // Flush in IDLE with cpu_en: nothing issued.
    cpu_flush = 1'b1;
    #1 chk("flush_idle_stall", cpu_stall, 0);
    tick();
    tick();
    chk("flush_idle_noreq", req, 0);
    cpu_en = 1'b0;
    cpu_flush = 1'b0;
    tick();

    // Asynchronous reset while in WAIT.
    push_req(1'b0, 2'd2, 32'h00004000, 32'h0);
    cpu_en = 1'b1;
    cpu_addr = 32'h00004000;
    tick();
    pop_chk("rst_req_fields");
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    chk("rst_pre_wait", {req, cpu_stall, cpu_rdata}, {2'b01, 32'h12345678});
    #2 resetn = 1'b0;
    #1 chk("reset_async",
           {req, wr, size, addr, wdata, cpu_rdata, cpu_stall}, 0);
    cpu_en = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    resetn = 1'b1;
    tick();

    t64(8'hFF, 2'd3);
    t64(8'h00, 2'd3);
    t64(8'h0F, 2'd2);
    t64(8'hF0, 2'd2);
    t64(8'h30, 2'd1);
    t64(8'h80, 2'd0);
    t64(8'h18, 2'd3);
    t64(8'h3C, 2'd3);

    chk("req_count", req_cnt, pushed);
    chk("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
